// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL/DIVU/REMU.
// Ports: clk, rst_n, in_valid/in_ready/in1/in2/operation, out_valid/out_ready/out/zero/overflow/illegal.
module alu_multicycle #(
    parameter int WIDTH         = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic             accept;
    logic             is_md;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;
    logic [WIDTH-1:0] md_res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign sum  = in1 + in2;
    assign diff = in1 - in2;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        is_md   = 1'b0;
        unique case (operation)
            OP_AND:  alu_res = in1 & in2;
            OP_OR:   alu_res = in1 | in2;
            OP_NOR:  alu_res = ~(in1 | in2);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                          (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                          (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, in1 < in2};
            OP_MUL, OP_DIVU, OP_REMU: begin
                is_md   = ENABLE_MULDIV;
                alu_ill = !ENABLE_MULDIV;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    generate
        if (ENABLE_MULDIV) begin : g_md
            // a_q: multiplicand / divisor
            // b_q: multiplier / dividend-then-quotient
            // acc_q: product / partial remainder
            logic [WIDTH-1:0] a_q, b_q, acc_q;
            logic [WIDTH-1:0] a_d, b_d, acc_d;
            logic [WIDTH:0]   rem_sh;
            logic [WIDTH:0]   rem_sub;

            always_comb begin
                a_d     = a_q;
                b_d     = b_q;
                acc_d   = acc_q;
                rem_sh  = {acc_q, b_q[WIDTH-1]};
                rem_sub = rem_sh - {1'b0, a_q};
                if (op_q == OP_MUL) begin
                    acc_d = acc_q + (b_q[0] ? a_q : '0);
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else if (!rem_sub[WIDTH]) begin
                    // no borrow: partial remainder >= divisor
                    acc_d = rem_sub[WIDTH-1:0];
                    b_d   = {b_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[WIDTH-1:0];
                    b_d   = {b_q[WIDTH-2:0], 1'b0};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else if (accept) begin
                    acc_q <= '0;
                    if (operation == OP_MUL) begin
                        a_q <= in1;
                        b_q <= in2;
                    end else begin
                        a_q <= in2;
                        b_q <= in1;
                    end
                end else if (state == BUSY) begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    acc_q <= acc_d;
                end
            end

            // result of the step being applied on the final BUSY edge
            assign md_res = (op_q == OP_DIVU) ? b_d : acc_d;
        end else begin : g_nomd
            assign md_res = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            out      <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= operation;
                        if (is_md) begin
                            state <= BUSY;
                            cnt   <= CW'(WIDTH);
                        end else begin
                            state    <= DONE;
                            out      <= alu_res;
                            zero     <= (alu_res == '0);
                            overflow <= alu_ovf;
                            illegal  <= alu_ill;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state    <= DONE;
                        out      <= md_res;
                        zero     <= (md_res == '0);
                        overflow <= 1'b0;
                        illegal  <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
